// File: rtl/quick_sort_pkg.sv
// quick_sort_pkg
//   Shared types for the quick_sort engine.
//   QS_AW / QS_DW : default address and data widths of the sorted RAM.
//   state_t       : controller states.
//   range_t       : one pending {lo, hi} index range held on the range stack.
package quick_sort_pkg;

  localparam int QS_AW = 6;
  localparam int QS_DW = 8;

  typedef enum logic [3:0] {
    IDLE,
    RANGE,
    PIVOT,
    SCAN,
    RDI,
    WRI,
    WRJ,
    FINAL_RD,
    FINAL_WR1,
    FINAL_WR2,
    SPLIT,
    POP,
    FINISH
  } state_t;

  typedef struct packed {
    logic [QS_AW-1:0] lo;
    logic [QS_AW-1:0] hi;
  } range_t;

endpackage

// File: rtl/qs_range_stack.sv
// qs_range_stack
//   LIFO of pending sort ranges.
//   clk, rst   : clock, synchronous active-low reset (empties the stack)
//   push       : store push_data on top
//   pop        : discard the top entry (ignored when empty)
//   push_data  : range to store
//   top        : current top entry (zero when empty)
//   empty      : no entries held
module qs_range_stack
  import quick_sort_pkg::*;
#(
  parameter int DEPTH = QS_AW + 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  range_t push_data,
  output range_t top,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH + 1);

  range_t         entries [DEPTH];
  logic [PW-1:0]  count;
  logic [PW-1:0]  top_idx;

  assign empty   = (count == '0);
  assign top_idx = count - 1'b1;
  assign top     = empty ? '0 : entries[top_idx];

  // The entry storage needs no reset; only the fill count is cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (push) begin
      entries[count] <= push_data;
      count          <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/quick_sort.sv
// quick_sort
//   In-place iterative quicksort (Lomuto partition) over RAM words
//   [left, right], ascending unsigned.
//   clk, rst     : clock, synchronous active-low reset
//   start        : one-cycle request, accepted only while idle
//   left, right  : inclusive index range, latched with start
//   done         : high once the last accepted sort has completed
//   mem_wr_en    : RAM write strobe, one cycle per write
//   mem_addr     : RAM address (read and write)
//   mem_wr_data  : RAM write data
//   mem_rd_data  : RAM read data, one cycle after the address is presented
// The range stack stores range_t, whose width follows the package QS_AW,
// so AW is changed through the package rather than per instance.
module quick_sort
  import quick_sort_pkg::*;
#(
  parameter int AW = QS_AW,
  parameter int DW = QS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] left,
  input  logic [AW-1:0] right,
  output logic          done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);

  state_t        state;
  logic [AW-1:0] lo, hi, i, j;
  logic [DW-1:0] pivot, aj, ai;
  logic          rd_wait;

  logic [AW-1:0] i_inc, i_dec, j_inc, lsize, rsize;
  logic          j_last, aj_lt, l_nonempty, r_nonempty;

  logic          stk_push, stk_pop, stk_empty;
  range_t        stk_in, stk_top;

  assign i_inc      = i + 1'b1;
  assign i_dec      = i - 1'b1;
  assign j_inc      = j + 1'b1;
  assign j_last     = (j_inc == hi);
  assign aj_lt      = (mem_rd_data < pivot);
  // After FINAL, i is the partition index p with lo <= p <= hi, so these
  // differences never wrap and p-1 / p+1 are only used when in range.
  assign lsize      = i - lo;
  assign rsize      = hi - i;
  assign l_nonempty = (i != lo);
  assign r_nonempty = (i != hi);

  // Only push when both halves survive: the larger goes on the stack so
  // the stack depth stays logarithmic in the range length.
  assign stk_push = (state == SPLIT) && l_nonempty && r_nonempty;
  assign stk_in   = (lsize > rsize) ? '{lo: lo, hi: i_dec} : '{lo: i_inc, hi: hi};
  assign stk_pop  = (state == POP) && !stk_empty;

  qs_range_stack #(.DEPTH(AW + 1)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (stk_in),
    .top       (stk_top),
    .empty     (stk_empty)
  );

  // Main controller. Every state that consumes read data first spends one
  // cycle with rd_wait set, because mem_addr is registered and the RAM adds
  // its own cycle of latency. A swap keeps both old values in registers so
  // the two writes can be issued back to back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      lo          <= '0;
      hi          <= '0;
      i           <= '0;
      j           <= '0;
      pivot       <= '0;
      aj          <= '0;
      ai          <= '0;
      rd_wait     <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo    <= left;
            hi    <= right;
            done  <= 1'b0;
            state <= RANGE;
          end
        end
        RANGE: begin
          if (lo >= hi) begin
            state <= POP;
          end else begin
            mem_addr <= hi;
            rd_wait  <= 1'b1;
            state    <= PIVOT;
          end
        end
        PIVOT: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            pivot    <= mem_rd_data;
            i        <= lo;
            j        <= lo;
            mem_addr <= lo;
            rd_wait  <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else if (aj_lt && (i != j)) begin
            aj       <= mem_rd_data;
            mem_addr <= i;
            rd_wait  <= 1'b1;
            state    <= RDI;
          end else begin
            j       <= j_inc;
            rd_wait <= 1'b1;
            if (aj_lt) i <= i_inc;
            if (j_last) begin
              mem_addr <= aj_lt ? i_inc : i;
              state    <= FINAL_RD;
            end else begin
              mem_addr <= j_inc;
            end
          end
        end
        RDI: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            ai          <= mem_rd_data;
            mem_addr    <= i;
            mem_wr_data <= aj;
            mem_wr_en   <= 1'b1;
            state       <= WRI;
          end
        end
        WRI: begin
          mem_addr    <= j;
          mem_wr_data <= ai;
          mem_wr_en   <= 1'b1;
          state       <= WRJ;
        end
        WRJ: begin
          i       <= i_inc;
          j       <= j_inc;
          rd_wait <= 1'b1;
          if (j_last) begin
            mem_addr <= i_inc;
            state    <= FINAL_RD;
          end else begin
            mem_addr <= j_inc;
            state    <= SCAN;
          end
        end
        FINAL_RD: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            mem_addr    <= hi;
            mem_wr_data <= mem_rd_data;
            mem_wr_en   <= 1'b1;
            state       <= FINAL_WR1;
          end
        end
        FINAL_WR1: begin
          mem_addr    <= i;
          mem_wr_data <= pivot;
          mem_wr_en   <= 1'b1;
          state       <= FINAL_WR2;
        end
        FINAL_WR2: begin
          state <= SPLIT;
        end
        SPLIT: begin
          if (l_nonempty && r_nonempty) begin
            if (lsize > rsize) lo <= i_inc;
            else               hi <= i_dec;
            state <= RANGE;
          end else if (l_nonempty) begin
            hi    <= i_dec;
            state <= RANGE;
          end else if (r_nonempty) begin
            lo    <= i_inc;
            state <= RANGE;
          end else begin
            state <= POP;
          end
        end
        POP: begin
          if (stk_empty) begin
            state <= FINISH;
          end else begin
            lo    <= stk_top.lo;
            hi    <= stk_top.hi;
            state <= RANGE;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_sort.sv
// tb_quick_sort
//   Self-checking bench for quick_sort: a behavioural RAM, a scoreboard of
//   expected RAM images (slice sorted with queue sort()), and a monitor that
//   compares the RAM and the write-address log whenever done rises.
module tb_quick_sort;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] left, right;
  logic          done;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;

  logic [DW-1:0]  ram [N];
  logic           load_req = 1'b0;
  logic [N*DW-1:0] load_img;

  int              tests = 0;
  int              fails = 0;
  logic [N*DW-1:0] exp_q [$];
  string           name_q [$];
  string           cur_name;
  int              cur_l, cur_r;
  int              wr_count, wr_bad;
  logic            prev_done;
  logic [N*DW-1:0] mon_img;
  string           mon_name;

  always #5 clk = ~clk;

  quick_sort dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .left        (left),
    .right       (right),
    .done        (done),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Synchronous RAM with one cycle of read latency; the bench preloads it
  // through load_req only while the engine is idle.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < N; k++) ram[k] <= load_img[k*DW +: DW];
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= ram[mem_addr];
  end

  task automatic checkOutput(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic loadRam(input logic [N*DW-1:0] img);
    load_img = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [N*DW-1:0] ramImage();
    logic [N*DW-1:0] img;
    for (int k = 0; k < N; k++) img[k*DW +: DW] = ram[k];
    return img;
  endfunction

  // Queues the expected image (current RAM with [l, r] sorted), pulses
  // start and waits a bounded number of cycles for done.
  task automatic applyStimulus(input int l, input int r, input int max_cycles,
                               output int lat);
    logic [DW-1:0]   q [$];
    logic [N*DW-1:0] img;
    img = ramImage();
    for (int k = l; k <= r; k++) q.push_back(ram[k]);
    q.sort();
    for (int k = 0; k < q.size(); k++) img[(l+k)*DW +: DW] = q[k];
    exp_q.push_back(img);
    name_q.push_back(cur_name);
    cur_l    = l;
    cur_r    = r;
    wr_count = 0;
    wr_bad   = 0;
    left     = AW'(l);
    right    = AW'(r);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < max_cycles) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: done=%0d after %0d cycles, want 1",
               cur_name, done, lat);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    logic [N*DW-1:0] img;
    logic [DW-1:0]   perm [N];
    logic [DW-1:0]   qa [$];
    logic [DW-1:0]   qb [$];
    logic [DW-1:0]   tmp;
    int              lat, idx, mism, l, r;

    rst       = 1'b0;
    start     = 1'b0;
    left      = '0;
    right     = '0;
    prev_done = 1'b0;
    cur_l     = 0;
    cur_r     = N - 1;

    // Monitor: logs writes and, on each rising done, checks the RAM against
    // the oldest queued expectation.
    fork
      forever begin
        @(negedge clk);
        if (rst && mem_wr_en) begin
          wr_count++;
          if (int'(mem_addr) < cur_l || int'(mem_addr) > cur_r) wr_bad++;
        end
        if (rst && done && !prev_done) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: done=1 with no pending sort");
          end else begin
            mon_img  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            for (int k = 0; k < N; k++)
              checkOutput($sformatf("%s_a[%0d]", mon_name, k),
                          int'(ram[k]), int'(mon_img[k*DW +: DW]));
            checkOutput({mon_name, "_writes_outside_range"}, wr_bad, 0);
          end
        end
        prev_done = done;
      end
    join_none

    repeat (3) @(negedge clk);
    checkOutput("reset_done",        int'(done),        0);
    checkOutput("reset_mem_wr_en",   int'(mem_wr_en),   0);
    checkOutput("reset_mem_addr",    int'(mem_addr),    0);
    checkOutput("reset_mem_wr_data", int'(mem_wr_data), 0);
    rst = 1'b1;
    @(negedge clk);

    // Shuffled permutation of 0..63 must come back as a[k] == k.
    for (int k = 0; k < N; k++) perm[k] = DW'(k);
    for (int k = N - 1; k > 0; k--) begin
      idx       = $urandom_range(k, 0);
      tmp       = perm[k];
      perm[k]   = perm[idx];
      perm[idx] = tmp;
    end
    for (int k = 0; k < N; k++) img[k*DW +: DW] = perm[k];
    loadRam(img);
    cur_name = "shuffle";
    applyStimulus(0, N - 1, 30000, lat);

    for (int k = 0; k < N; k++) img[k*DW +: DW] = DW'(N - 1 - k);
    loadRam(img);
    cur_name = "reverse";
    applyStimulus(0, N - 1, 30000, lat);

    for (int k = 0; k < N; k++) img[k*DW +: DW] = 8'hA5;
    loadRam(img);
    cur_name = "all_a5";
    applyStimulus(0, N - 1, 30000, lat);
    checkOutput("all_a5_done", int'(done), 1);

    for (int k = 0; k < N; k++) img[k*DW +: DW] = DW'($urandom_range(255, 0));
    loadRam(img);
    cur_name = "sub_10_20";
    applyStimulus(10, 20, 30000, lat);

    cur_name = "deg_5_5";
    applyStimulus(5, 5, 4, lat);
    checkOutput("deg_5_5_done_by4", (done && lat <= 4) ? 1 : 0, 1);
    checkOutput("deg_5_5_writes", wr_count, 0);

    cur_name = "deg_7_3";
    applyStimulus(7, 3, 4, lat);
    checkOutput("deg_7_3_done_by4", (done && lat <= 4) ? 1 : 0, 1);
    checkOutput("deg_7_3_writes", wr_count, 0);

    // Random data with many duplicate keys over random ranges.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < N; k++) img[k*DW +: DW] = DW'($urandom_range(15, 0));
      loadRam(img);
      l = $urandom_range(N - 1, 0);
      r = $urandom_range(N - 1, 0);
      if (l > r) begin
        idx = l;
        l   = r;
        r   = idx;
      end
      cur_name = $sformatf("rand%0d_%0d_%0d", t, l, r);
      applyStimulus(l, r, 30000, lat);
    end

    // Reset in the middle of a full sort. Reset lands on a cycle with no
    // write strobe so no swap is left half written.
    for (int k = 0; k < N; k++) img[k*DW +: DW] = DW'($urandom_range(255, 0));
    loadRam(img);
    qa.delete();
    for (int k = 0; k < N; k++) qa.push_back(ram[k]);
    qa.sort();
    cur_l    = 0;
    cur_r    = N - 1;
    left     = '0;
    right    = AW'(N - 1);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    idx = 0;
    while (mem_wr_en && idx < 50) begin
      @(negedge clk);
      idx++;
    end
    checkOutput("midreset_found_idle_write_slot", int'(mem_wr_en), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_done",      int'(done),      0);
    checkOutput("midreset_mem_wr_en", int'(mem_wr_en), 0);
    rst = 1'b1;
    @(negedge clk);
    qb.delete();
    for (int k = 0; k < N; k++) qb.push_back(ram[k]);
    qb.sort();
    mism = 0;
    for (int k = 0; k < N; k++) if (qa[k] != qb[k]) mism++;
    checkOutput("midreset_permutation_mismatches", mism, 0);

    cur_name = "after_reset";
    applyStimulus(0, N - 1, 30000, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quick_sort.md
Name: quick_sort

Overview:
- In-place hardware quicksort engine.
- Sorts the inclusive address range [left, right] of an external single-port synchronous RAM into ascending unsigned order.
- Sits between a controller, which issues start/left/right and waits for done, and a BRAM port (dport_bram port A) that it owns exclusively while busy.
- Iterative Lomuto partitioning with an internal range stack; no recursion.

Parameters:
- AW, 6, memory address width; the RAM holds up to 2^AW words.
- DW, 8, data word width; compared as unsigned.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets at the next clk edge).
- start  in  1  one-cycle request; sampled only in IDLE.
- left  in  AW  first index of the range; sampled with start.
- right  in  AW  last index of the range (inclusive); sampled with start.
- done  out  1  high when the last requested sort has completed.
- mem_wr_en  out  1  write strobe to the RAM.
- mem_addr  out  AW  RAM address for both read and write.
- mem_wr_data  out  DW  RAM write data.
- mem_rd_data  in  DW  RAM read data; valid exactly 1 cycle after the address is presented.

Behaviour:
- Reset (rst=0): state IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, stack empty.
- Memory model: synchronous RAM, write-first irrelevant (no same-address read/write in one cycle). A read costs 1 wait cycle.
- IDLE: on start=1, latch lo=left, hi=right, clear done, push nothing, go to RANGE. start while not IDLE is ignored.
- RANGE: if lo>=hi, go to POP. Otherwise issue read of a[hi], go to PIVOT.
- PIVOT: capture pivot=mem_rd_data. Set i=lo, j=lo, issue read a[j], go to SCAN.
- SCAN (per j<hi):
  - capture aj.
  - If aj<pivot and i!=j: read a[i] (RDI), then write a[i]=aj (WRI), then write a[j]=old a[i] (WRJ). Then i++.
  - If aj<pivot and i==j: i++ with no writes.
  - Then j++, issue read a[j].
  - When j==hi, go to FINAL.
- FINAL: read a[i]; write a[hi]=a[i]; write a[i]=pivot. Partition index p=i.
- Split:
  - Subranges are [lo,p-1] and [p+1,hi]; empty ranges (p==lo or p==hi) are dropped, with no address underflow or overflow.
  - Push the larger non-empty subrange onto the stack and continue with the smaller one (set lo/hi, go to RANGE). This bounds stack depth to AW+1 entries.
- POP: if stack empty, go to FINISH. Else pop {lo,hi}, go to RANGE.
- FINISH: done=1, go to IDLE. done stays high until the next accepted start.
- mem_wr_en is asserted only in write cycles, for exactly one cycle each. No write ever targets an address outside [left, right].
- left>right or left==right: no memory writes; done rises within 4 cycles of start.
- Equal keys are allowed: the comparison is strict (<), so the algorithm terminates. Final ordering is nondecreasing.
- Stack overflow is impossible by construction. The stack has AW+1 entries, each 2*AW bits.
- Reset mid-operation: returns to IDLE immediately with done=0. RAM contents are left partially sorted (a permutation of the original).

Decomposition:
- Package quick_sort_pkg: state enum (IDLE, RANGE, PIVOT, SCAN, RDI, WRI, WRJ, FINAL_RD, FINAL_WR1, FINAL_WR2, SPLIT, POP, FINISH) and the range_t struct {lo, hi}.
- One sub-module: qs_range_stack, a LIFO of depth AW+1 with push, pop, top, empty and sync active-low reset.

Test Plan:
- 64 distinct values (a permutation of 0..63, shuffled); start with left=0, right=63 -> done rises; a[k]==k for all k.
- Reverse-sorted 63..0, full range -> ascending; done asserted; no write outside 0..63.
- All 64 words = 8'hA5 -> done rises; contents unchanged (every word still A5).
- Subrange left=10, right=20 on random data -> a[10..20] nondecreasing and a permutation of the original; a[0..9] and a[21..63] bit-identical to before.
- left=right=5 and left=7, right=3 -> done within 4 cycles; mem_wr_en never asserted.
- Assert rst=0 midway through a full sort -> next cycle done=0 and mem_wr_en=0; memory is a permutation of the original. A new start then yields a fully sorted array.
